// File: rtl/mux_stream_rr_if.sv
// ---------------------------------------------------------------------------
// mux_stream_rr_if
//
// Purpose:
//   Bundles the stream-side signals of mux_stream_rr: the CHANNELS upstream
//   valid/ready/data lanes and the single downstream valid/ready/data/chan
//   lane. Control inputs (mode, sel) and clk/rst_n stay as plain ports on
//   the multiplexer itself.
//
// Signals:
//   in_data   CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
//   in_valid  CHANNELS        per-channel valid (producers -> mux)
//   in_ready  CHANNELS        per-channel ready (mux -> producers)
//   out_data  WIDTH           registered selected word (mux -> consumer)
//   out_chan  SEL_W           index of the channel that supplied out_data
//   out_valid 1               registered output valid (mux -> consumer)
//   out_ready 1               downstream ready (consumer -> mux)
//
// Modports:
//   master  environment side (drives producer lanes and consumer ready)
//   slave   multiplexer side
// ---------------------------------------------------------------------------
interface mux_stream_rr_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = $clog2(CHANNELS)
);

    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_chan,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_chan,
        output out_valid
    );

endinterface

// File: rtl/mux_stream_rr.sv
// ---------------------------------------------------------------------------
// mux_stream_rr
//
// Purpose:
//   N-channel, W-bit stream multiplexer with a single registered output
//   stage. In fixed mode the channel named by sel is forwarded; in
//   round-robin mode the channel after the last granted one (wrapping) with
//   valid set wins. One cycle latency, one word per cycle with out_ready
//   held high, full backpressure via per-channel in_ready.
//
// Ports:
//   clk    sole clock, rising edge
//   rst_n  asynchronous active-low reset
//   mode   0 = fixed select, 1 = round-robin
//   sel    channel index for fixed mode; values >= CHANNELS select nothing
//   bus    mux_stream_rr_if.slave carrying in_data/in_valid/in_ready and
//          out_data/out_chan/out_valid/out_ready
// ---------------------------------------------------------------------------
module mux_stream_rr #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    mux_stream_rr_if.slave   bus
);

    // Output stage registers and the round-robin pointer
    logic [WIDTH-1:0]    out_data_q;
    logic [SEL_W-1:0]    out_chan_q;
    logic                out_valid_q;
    logic [SEL_W-1:0]    last_q;

    // Combinational arbitration results
    logic                advance;
    logic                grant_valid;
    logic [SEL_W-1:0]    grant;
    logic [WIDTH-1:0]    grant_data;
    logic [CHANNELS-1:0] in_ready_c;
    logic                transfer;

    // The output register can take a new word when it is empty or when the
    // word it holds is being consumed in this same cycle.
    assign advance = !out_valid_q || bus.out_ready;

    // Grant selection. Fixed mode compares sel against every legal index so
    // an out-of-range sel simply matches nothing. Round-robin walks the
    // channels from farthest to nearest after the pointer, so the nearest
    // valid channel is the last one written and therefore wins; the pointer
    // itself is at distance CHANNELS, i.e. it is considered last.
    always_comb begin
        int idx;
        grant_valid = 1'b0;
        grant       = '0;
        idx         = 0;
        if (!mode) begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (sel == SEL_W'(k) && bus.in_valid[k]) begin
                    grant_valid = 1'b1;
                    grant       = SEL_W'(k);
                end
            end
        end else begin
            for (int i = CHANNELS; i >= 1; i--) begin
                idx = int'(last_q) + i;
                if (idx >= CHANNELS) begin
                    idx = idx - CHANNELS;
                end
                if (bus.in_valid[idx]) begin
                    grant_valid = 1'b1;
                    grant       = SEL_W'(idx);
                end
            end
        end
    end

    // Data steering for the granted channel and the one-hot ready vector.
    // in_ready only depends on other channels' valids through the grant.
    always_comb begin
        grant_data = '0;
        in_ready_c = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (grant == SEL_W'(k)) begin
                grant_data    = bus.in_data[k*WIDTH +: WIDTH];
                in_ready_c[k] = advance && grant_valid;
            end
        end
    end

    // A grant always refers to a valid channel, so a granted channel with
    // the output stage advancing is exactly a handshake.
    assign transfer = advance && grant_valid;

    // Output stage and pointer. On a transfer the word, its source index and
    // the pointer all update; the pointer moves in fixed mode too. When the
    // stage advances with nothing granted it just empties, leaving the stale
    // payload in place. Reset points at the highest channel so channel 0 is
    // first in line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            last_q      <= SEL_W'(CHANNELS - 1);
        end else if (transfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= grant_data;
            out_chan_q  <= grant;
            last_q      <= grant;
        end else if (advance) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
    assign bus.out_valid = out_valid_q;

endmodule
